// File: rtl/param_dual_clcg_rng.sv
`default_nettype none
// ============================================================================
// Module   : param_dual_clcg_rng
// Brief    : Four coupled LCGs produce one random bit per step. Bits are packed
//            LSB first into words on a valid/ready port.
//            Optional repetition health test: define CLCG_HEALTH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module param_dual_clcg_rng #(
    parameter int WIDTH     = 16,
    parameter int OUT_BITS  = 8,
    parameter int R1        = 2,
    parameter int R2        = 3,
    parameter int R3        = 2,
    parameter int R4        = 3,
    parameter int B1        = 7,
    parameter int B2        = 11,
    parameter int B3        = 5,
    parameter int B4        = 3,
    parameter int RUN_LIMIT = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_x,
    input  logic [WIDTH-1:0]    seed_y,
    input  logic [WIDTH-1:0]    seed_p,
    input  logic [WIDTH-1:0]    seed_q,
    input  logic                en,
    output logic [OUT_BITS-1:0] rnd_word,
    output logic                rnd_valid,
    input  logic                rnd_ready,
    output logic                seeded,
    output logic                health_fail
);

    localparam int                c_CNT_W    = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(OUT_BITS - 1);
    localparam logic [WIDTH-1:0]  c_B1       = WIDTH'(B1);
    localparam logic [WIDTH-1:0]  c_B2       = WIDTH'(B2);
    localparam logic [WIDTH-1:0]  c_B3       = WIDTH'(B3);
    localparam logic [WIDTH-1:0]  c_B4       = WIDTH'(B4);

    if (WIDTH < 4 || WIDTH > 32 || OUT_BITS < 1 || OUT_BITS > 32 ||
        R1 < 1 || R1 >= WIDTH || R2 < 1 || R2 >= WIDTH ||
        R3 < 1 || R3 >= WIDTH || R4 < 1 || R4 >= WIDTH || RUN_LIMIT < 1) begin : g_bad_params
        $error("param_dual_clcg_rng: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1
`ifdef CLCG_HEALTH_EN
        ,
        S_FAIL = 2'd2
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      x1_q, x1_d, x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
    logic [WIDTH-1:0]      x1_n, x2_n, x3_n, x4_n;
    logic [c_CNT_W-1:0]    cnt_q, cnt_d;
    logic [OUT_BITS-1:0]   pack_q, pack_d, word_q, word_d, pack_set;
    logic                  valid_q, valid_d;
    logic                  c1, c2, z, stall, step, load;

`ifdef CLCG_HEALTH_EN
    localparam int             c_RUN_W   = $clog2(RUN_LIMIT + 1);
    localparam logic [c_RUN_W-1:0] c_RUN_LIM = c_RUN_W'(RUN_LIMIT);
    localparam logic [c_RUN_W-1:0] c_RUN_ONE = c_RUN_W'(1);
    logic [c_RUN_W-1:0]        run_q, run_d;
    logic                      last_z_q, last_z_d, hf_q, hf_d;
`endif

    // Multiplier 2^sh+1 realised as shift-and-add; the sum wraps at WIDTH bits.
    function automatic logic [WIDTH-1:0] lcg_next(input logic [WIDTH-1:0] x,
                                                  input int sh,
                                                  input logic [WIDTH-1:0] inc);
        return x + (x << sh) + inc;
    endfunction

    assign x1_n = lcg_next(x1_q, R1, c_B1);
    assign x2_n = lcg_next(x2_q, R2, c_B2);
    assign x3_n = lcg_next(x3_q, R3, c_B3);
    assign x4_n = lcg_next(x4_q, R4, c_B4);
    assign c1   = (x1_n > x2_n);
    assign c2   = (x3_n > x4_n);
    assign z    = x2_n[0] ? c1 : c2;

    always_comb begin
        stall    = (cnt_q == c_CNT_LAST) && valid_q && !rnd_ready;
        step     = (state_q == S_RUN) && en && !stall;
`ifdef CLCG_HEALTH_EN
        load     = seed_load && (state_q != S_FAIL);
`else
        load     = seed_load;
`endif
        pack_set = pack_q;
        pack_set[cnt_q] = z;

        state_d  = state_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        x3_d     = x3_q;
        x4_d     = x4_q;
        cnt_d    = cnt_q;
        pack_d   = pack_q;
        word_d   = word_q;
        valid_d  = valid_q;
`ifdef CLCG_HEALTH_EN
        run_d    = run_q;
        last_z_d = last_z_q;
        hf_d     = hf_q;
`endif

        if (valid_q && rnd_ready) begin
            valid_d = 1'b0;
        end

        if (load) begin
            x1_d    = seed_x;
            x2_d    = seed_y;
            x3_d    = seed_p;
            x4_d    = seed_q;
            cnt_d   = '0;
            pack_d  = '0;
            valid_d = 1'b0;
            state_d = S_RUN;
`ifdef CLCG_HEALTH_EN
            run_d   = '0;
`endif
        end else if (step) begin
            x1_d   = x1_n;
            x2_d   = x2_n;
            x3_d   = x3_n;
            x4_d   = x4_n;
            pack_d = pack_set;
            if (cnt_q == c_CNT_LAST) begin
                // A completing word may overwrite one being transferred this cycle.
                word_d  = pack_set;
                valid_d = 1'b1;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + 1'b1;
            end
`ifdef CLCG_HEALTH_EN
            run_d    = (run_q == '0 || z != last_z_q) ? c_RUN_ONE : run_q + 1'b1;
            last_z_d = z;
            if (run_d == c_RUN_LIM) begin
                hf_d    = 1'b1;
                state_d = S_FAIL;
            end
`endif
        end

`ifdef CLCG_HEALTH_EN
        if (state_d == S_FAIL) begin
            valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            x1_q     <= '0;
            x2_q     <= '0;
            x3_q     <= '0;
            x4_q     <= '0;
            cnt_q    <= '0;
            pack_q   <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
`ifdef CLCG_HEALTH_EN
            run_q    <= '0;
            last_z_q <= 1'b0;
            hf_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            x3_q     <= x3_d;
            x4_q     <= x4_d;
            cnt_q    <= cnt_d;
            pack_q   <= pack_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
`ifdef CLCG_HEALTH_EN
            run_q    <= run_d;
            last_z_q <= last_z_d;
            hf_q     <= hf_d;
`endif
        end
    end

    assign rnd_word  = word_q;
    assign rnd_valid = valid_q;
    assign seeded    = (state_q == S_RUN);
`ifdef CLCG_HEALTH_EN
    assign health_fail = hf_q;
`else
    assign health_fail = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_param_dual_clcg_rng.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_dual_clcg_rng
// Brief    : Scoreboard bench: default-parameter instance plus a 4-bit/1-bit
//            legacy instance, both checked against a reference LCG model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_dual_clcg_rng;

    localparam int W   = 16;
    localparam int OB  = 8;
    localparam int LW  = 4;
    localparam int LOB = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          d_seed_load, d_en, d_ready, d_valid, d_seeded, d_hf;
    logic [W-1:0]  d_sx, d_sy, d_sp, d_sq;
    logic [OB-1:0] d_word;

    logic           l_seed_load, l_en, l_ready, l_valid, l_seeded, l_hf;
    logic [LW-1:0]  l_sx, l_sy, l_sp, l_sq;
    logic [LOB-1:0] l_word;

    param_dual_clcg_rng dut (
        .clk(clk), .rst_n(rst_n), .seed_load(d_seed_load),
        .seed_x(d_sx), .seed_y(d_sy), .seed_p(d_sp), .seed_q(d_sq),
        .en(d_en), .rnd_word(d_word), .rnd_valid(d_valid), .rnd_ready(d_ready),
        .seeded(d_seeded), .health_fail(d_hf)
    );

    param_dual_clcg_rng #(.WIDTH(LW), .OUT_BITS(LOB)) dut_leg (
        .clk(clk), .rst_n(rst_n), .seed_load(l_seed_load),
        .seed_x(l_sx), .seed_y(l_sy), .seed_p(l_sp), .seed_q(l_sq),
        .en(l_en), .rnd_word(l_word), .rnd_valid(l_valid), .rnd_ready(l_ready),
        .seeded(l_seeded), .health_fail(l_hf)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] q_dft[$];
    logic [31:0] q_leg[$];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] lcg(input logic [31:0] x, input int sh, input int inc, input int w);
        logic [31:0] m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (x + (x << sh) + 32'(inc)) & m;
    endfunction

    task automatic push_words(input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3,
                              input int w, input int ob, input int n, input bit leg);
        logic [31:0] a, b, c, d, word;
        a = s0; b = s1; c = s2; d = s3;
        for (int i = 0; i < n; i++) begin
            word = '0;
            for (int k = 0; k < ob; k++) begin
                a = lcg(a, 2, 7, w);
                b = lcg(b, 3, 11, w);
                c = lcg(c, 2, 5, w);
                d = lcg(d, 3, 3, w);
                word[k] = b[0] ? (a > b) : (c > d);
            end
            if (leg) q_leg.push_back(word);
            else     q_dft.push_back(word);
        end
    endtask

    // Scoreboard: every accepted word is compared with the next model word.
    always @(negedge clk) begin
        if (rst_n && d_valid && d_ready && !d_seed_load) begin
            if (q_dft.size() == 0) check_eq("dft_unexpected_word", 32'(d_word), 32'hFFFF_FFFF);
            else                   check_eq("dft_word", 32'(d_word), q_dft.pop_front());
        end
        if (rst_n && l_valid && l_ready && !l_seed_load) begin
            if (q_leg.size() == 0) check_eq("leg_unexpected_bit", 32'(l_word), 32'hFFFF_FFFF);
            else                   check_eq("leg_bit", 32'(l_word), q_leg.pop_front());
        end
    end

    task automatic wait_dft_valid(input int budget, input string tag);
        int k;
        k = 0;
        while (!d_valid && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq(tag, 32'(d_valid), 32'd1);
    endtask

    task automatic check_latency(input string tag);
        for (int i = 1; i < OB; i++) begin
            @(posedge clk); #1;
            check_eq({tag, "_early"}, 32'(d_valid), 32'd0);
        end
        @(posedge clk); #1;
        check_eq({tag, "_valid"}, 32'(d_valid), 32'd1);
        check_eq({tag, "_word"}, 32'(d_word), q_dft[0]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        d_seed_load = 1'b0; d_en = 1'b0; d_ready = 1'b0;
        d_sx = '0; d_sy = '0; d_sp = '0; d_sq = '0;
        l_seed_load = 1'b0; l_en = 1'b0; l_ready = 1'b0;
        l_sx = '0; l_sy = '0; l_sp = '0; l_sq = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 32'(d_valid), 32'd0);
        check_eq("rst_word", 32'(d_word), 32'd0);
        check_eq("rst_seeded", 32'(d_seeded), 32'd0);
        check_eq("rst_health", 32'(d_hf), 32'd0);
        check_eq("rst_leg_valid", 32'(l_valid), 32'd0);
        rst_n = 1'b1;

        // Enabled but unseeded: IDLE takes no steps.
        d_en = 1'b1; d_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("idle_valid", 32'(d_valid), 32'd0);
        check_eq("idle_seeded", 32'(d_seeded), 32'd0);

        // Legacy 4-bit, one bit per word.
        l_sx = 4'd1; l_sy = 4'd2; l_sp = 4'd3; l_sq = 4'd4;
        l_en = 1'b1; l_ready = 1'b1;
        push_words(1, 2, 3, 4, LW, LOB, 17, 1'b1);
        l_seed_load = 1'b1;
        @(posedge clk); #1;
        l_seed_load = 1'b0;
        check_eq("leg_seeded", 32'(l_seeded), 32'd1);
        check_eq("leg_load_valid", 32'(l_valid), 32'd0);
        @(posedge clk); #1;
        check_eq("leg_first_valid", 32'(l_valid), 32'd1);
        check_eq("leg_first_bit", 32'(l_word), 32'd0);
        repeat (16) @(posedge clk);
        #1;
        l_en = 1'b0;
        @(posedge clk); #1;
        check_eq("leg_all_bits_taken", 32'(q_leg.size()), 32'd0);
        check_eq("leg_valid_drop", 32'(l_valid), 32'd0);

        // Default parameters, first word held under back-pressure.
        d_sx = 16'h1234; d_sy = 16'hBEEF; d_sp = 16'h0F0F; d_sq = 16'hA5A5;
        d_ready = 1'b0; d_en = 1'b1;
        push_words(32'h1234, 32'hBEEF, 32'h0F0F, 32'hA5A5, W, OB, 10, 1'b0);
        d_seed_load = 1'b1;
        @(posedge clk); #1;
        d_seed_load = 1'b0;
        check_eq("load_seeded", 32'(d_seeded), 32'd1);
        check_eq("load_valid", 32'(d_valid), 32'd0);
        check_latency("lat");
        repeat (20) @(posedge clk);
        #1;
        check_eq("stall_valid", 32'(d_valid), 32'd1);
        check_eq("stall_word", 32'(d_word), q_dft[0]);
        d_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        d_en = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        d_en = 1'b1;
        repeat (24) @(posedge clk);
        #1;
        check_eq("words_taken", 32'(q_dft.size()), 32'd5);

        // Reseed mid-word (cnt=5) with a word still pending.
        d_ready = 1'b0;
        wait_dft_valid(20, "mid_wait_valid");
        repeat (5) @(posedge clk);
        #1;
        check_eq("mid_pending_valid", 32'(d_valid), 32'd1);
        d_sx = 16'hCAFE; d_sy = 16'h0001; d_sp = 16'h8000; d_sq = 16'h7FFF;
        q_dft.delete();
        push_words(32'hCAFE, 32'h0001, 32'h8000, 32'h7FFF, W, OB, 6, 1'b0);
        d_seed_load = 1'b1;
        @(posedge clk); #1;
        d_seed_load = 1'b0;
        check_eq("reseed_valid_clear", 32'(d_valid), 32'd0);
        d_ready = 1'b1;
        check_latency("relat");
        repeat (17) @(posedge clk);
        #1;
        check_eq("reseed_words_taken", 32'(q_dft.size()), 32'd3);

        // Asynchronous reset pulse between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_valid", 32'(d_valid), 32'd0);
        check_eq("arst_word", 32'(d_word), 32'd0);
        check_eq("arst_seeded", 32'(d_seeded), 32'd0);
        #2;
        rst_n = 1'b1;
        q_dft.delete();
        repeat (12) @(posedge clk);
        #1;
        check_eq("post_arst_valid", 32'(d_valid), 32'd0);
        check_eq("post_arst_seeded", 32'(d_seeded), 32'd0);
        check_eq("post_arst_health", 32'(d_hf), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
